// File: rtl/reg_bank_write_arbiter.sv
// reg_bank_write_arbiter
//   Round-robin arbiter sharing the write port of a DEPTH x WIDTH register bank
//   among N_REQ requesters. One accept per cycle over valid/ready. The accepted
//   request becomes a registered one-hot write enable plus write data one cycle later.
//   An accepted request whose address is out of range produces an err pulse and no write.
// Optional feature: `define REG_ARB_LOCK_EN adds req_lock and a LOCK state in which
//   the lock owner keeps the grant until it releases the lock or withdraws its request.
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req_valid  per-requester request valid            [N_REQ]
//   req_addr   per-requester register address         [N_REQ*AW]
//   req_data   per-requester write data               [N_REQ*WIDTH]
//   req_lock   per-requester lock request (macro only) [N_REQ]
//   req_ready  one-hot grant, combinational           [N_REQ]
//   wr_en      one-hot register enable, registered    [DEPTH]
//   wr_data    write data, registered                 [WIDTH]
//   err        one-cycle pulse for an out-of-range accept
//   busy       any request pending or a write pulse in flight
module reg_bank_write_arbiter #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ*AW-1:0]    req_addr,
  input  logic [N_REQ*WIDTH-1:0] req_data,
`ifdef REG_ARB_LOCK_EN
  input  logic [N_REQ-1:0]       req_lock,
`endif
  output logic [N_REQ-1:0]       req_ready,
  output logic [DEPTH-1:0]       wr_en,
  output logic [WIDTH-1:0]       wr_data,
  output logic                   err,
  output logic                   busy
);

  localparam int unsigned PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
`ifdef REG_ARB_LOCK_EN
  localparam logic [1:0] LOCK  = 2'd2;
`endif

  logic [1:0]       state_q, state_d;
  logic [PW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]    grant_idx;
  logic             grant_any;
  logic [PW-1:0]    nxt_ptr;
  logic [AW-1:0]    sel_addr;
  logic [WIDTH-1:0] sel_data;
  logic [DEPTH-1:0] wr_en_d;
  logic [WIDTH-1:0] wr_data_d;
  logic             err_d;
  int unsigned      idx;
`ifdef REG_ARB_LOCK_EN
  logic [PW-1:0]    lock_owner_q, lock_owner_d;
  logic [PW-1:0]    owner_nxt;
`endif

  // Arbitration: first valid requester at or after rr_ptr, wrapping; lock owner only in LOCK.
  always_comb begin
    req_ready = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    idx       = 0;
    if (reset) begin
`ifdef REG_ARB_LOCK_EN
      if (state_q == LOCK) begin
        if (req_valid[lock_owner_q]) begin
          grant_idx = lock_owner_q;
          grant_any = 1'b1;
        end
      end else
`endif
      begin
        for (int unsigned k = 0; k < N_REQ; k++) begin
          idx = 32'(rr_ptr_q) + k;
          if (idx >= N_REQ) idx = idx - N_REQ;
          if (!grant_any && req_valid[PW'(idx)]) begin
            grant_any = 1'b1;
            grant_idx = PW'(idx);
          end
        end
      end
      if (grant_any) req_ready[grant_idx] = 1'b1;
    end
  end

  // Payload mux for the granted requester.
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign nxt_ptr = (grant_idx == PW'(N_REQ-1)) ? '0 : grant_idx + PW'(1);
`ifdef REG_ARB_LOCK_EN
  assign owner_nxt = (lock_owner_q == PW'(N_REQ-1)) ? '0 : lock_owner_q + PW'(1);
`endif

  assign busy = (|req_valid) | (|wr_en);

  // Next state, pointer and registered bank outputs.
  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    wr_en_d   = '0;
    wr_data_d = wr_data;
    err_d     = 1'b0;
`ifdef REG_ARB_LOCK_EN
    lock_owner_d = lock_owner_q;
`endif

    if (grant_any) begin
      if (32'(sel_addr) < DEPTH) begin
        wr_en_d   = DEPTH'(1) << sel_addr;
        wr_data_d = sel_data;
      end else begin
        err_d = 1'b1;
      end
    end

`ifdef REG_ARB_LOCK_EN
    if (state_q == LOCK) begin
      // Pointer stays frozen while locked; release resumes after the owner.
      if (!req_valid[lock_owner_q]) begin
        rr_ptr_d = owner_nxt;
        state_d  = (|req_valid) ? GRANT : IDLE;
      end else if (grant_any && !req_lock[grant_idx]) begin
        rr_ptr_d = nxt_ptr;
        state_d  = GRANT;
      end
    end else if (grant_any && req_lock[grant_idx]) begin
      state_d      = LOCK;
      lock_owner_d = grant_idx;
    end else
`endif
    begin
      if (grant_any) rr_ptr_d = nxt_ptr;
      case (state_q)
        IDLE:    if (|req_valid)  state_d = GRANT;
        GRANT:   if (!(|req_valid)) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      wr_en    <= '0;
      wr_data  <= '0;
      err      <= 1'b0;
`ifdef REG_ARB_LOCK_EN
      lock_owner_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      wr_en    <= wr_en_d;
      wr_data  <= wr_data_d;
      err      <= err_d;
`ifdef REG_ARB_LOCK_EN
      lock_owner_q <= lock_owner_d;
`endif
    end
  end

endmodule

// File: tb/tb_reg_bank_write_arbiter.sv
// Scoreboard bench for reg_bank_write_arbiter (DEPTH=3 so an out-of-range address exists).
module tb_reg_bank_write_arbiter;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned N_REQ = 3;
  localparam int unsigned AW    = 2;

  typedef struct packed {
    logic [DEPTH-1:0] en;
    logic [WIDTH-1:0] data;
    logic             err;
  } exp_t;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic [N_REQ-1:0]       req_valid = '0;
  logic [N_REQ*AW-1:0]    req_addr = '0;
  logic [N_REQ*WIDTH-1:0] req_data = '0;
`ifdef REG_ARB_LOCK_EN
  logic [N_REQ-1:0]       req_lock = '0;
  logic [N_REQ-1:0]       lock_cfg = '0;
`endif
  logic [N_REQ-1:0]       req_ready;
  logic [DEPTH-1:0]       wr_en;
  logic [WIDTH-1:0]       wr_data;
  logic                   err;
  logic                   busy;

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [WIDTH-1:0] last_data = '0;

  reg_bank_write_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_REQ(N_REQ), .AW(AW)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_addr(req_addr),
    .req_data(req_data),
`ifdef REG_ARB_LOCK_EN
    .req_lock(req_lock),
`endif
    .req_ready(req_ready),
    .wr_en(wr_en),
    .wr_data(wr_data),
    .err(err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every write or error pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (wr_en != '0 || err) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual wr_en=%b err=%b data=%h required none at %0t",
                 wr_en, err, wr_data, $time);
      end else begin
        e = exp_q.pop_front();
        if (wr_en !== e.en || wr_data !== e.data || err !== e.err) begin
          errors++;
          $display("FAIL write_pulse actual wr_en=%b data=%h err=%b required wr_en=%b data=%h err=%b at %0t",
                   wr_en, wr_data, err, e.en, e.data, e.err, $time);
        end
      end
    end
  end

  // Apply one cycle of requests, check the grant, and push the expected bank response.
  task automatic drive(input logic [2:0] v, input logic [5:0] a, input logic [23:0] d,
                       input logic [2:0] exp_ready, input bit push);
    int w;
    logic [1:0] ad;
    logic [7:0] dd;
    exp_t e;
    @(posedge clk);
    #1;
    req_valid = v;
    req_addr  = a;
    req_data  = d;
`ifdef REG_ARB_LOCK_EN
    req_lock  = lock_cfg;
`endif
    #3;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (v != 3'b000) check("busy", 32'(busy), 32'd1);
    if (push && exp_ready != 3'b000) begin
      w  = (exp_ready == 3'b001) ? 0 : (exp_ready == 3'b010) ? 1 : 2;
      ad = a[w*2 +: 2];
      dd = d[w*8 +: 8];
      if (ad < 2'd3) begin
        e.en = 3'b001 << ad; e.data = dd; e.err = 1'b0;
        last_data = dd;
      end else begin
        e.en = 3'b000; e.data = last_data; e.err = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset: outputs cleared and no grant even with requests present.
    req_valid = 3'b111;
    #12;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    req_valid = 3'b000;
    #10;
    reset = 1'b1;

    // Idle for 10 cycles.
    repeat (10) begin
      @(posedge clk);
      #4;
      check("idle_ready", 32'(req_ready), 32'd0);
      check("idle_wr_en", 32'(wr_en), 32'd0);
      check("idle_err", 32'(err), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Single R1 write to register 2; then R2 alone to move the pointer to 0.
    drive(3'b010, {2'd0, 2'd2, 2'd0}, {8'h00, 8'hA5, 8'h00}, 3'b010, 1);
    drive(3'b100, {2'd1, 2'd0, 2'd0}, {8'h3C, 8'h00, 8'h00}, 3'b100, 1);

    // All requesters valid for 6 cycles: strict rotation R0,R1,R2,R0,R1,R2.
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'h32, 8'h21, 8'h10}, 3'b001, 1);
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'h32, 8'h21, 8'h10}, 3'b010, 1);
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'h32, 8'h21, 8'h10}, 3'b100, 1);
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'h33, 8'h22, 8'h11}, 3'b001, 1);
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'h33, 8'h22, 8'h11}, 3'b010, 1);
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'h33, 8'h22, 8'h11}, 3'b100, 1);

    // Single requester holding valid is granted every cycle.
    drive(3'b010, {2'd0, 2'd0, 2'd0}, {8'h00, 8'h77, 8'h00}, 3'b010, 1);
    drive(3'b010, {2'd0, 2'd0, 2'd0}, {8'h00, 8'h78, 8'h00}, 3'b010, 1);
    drive(3'b010, {2'd0, 2'd0, 2'd0}, {8'h00, 8'h79, 8'h00}, 3'b010, 1);

    // Out-of-range address from R2: err pulse, no write, pointer still wraps to R0.
    drive(3'b100, {2'd3, 2'd0, 2'd0}, {8'hEE, 8'h00, 8'h00}, 3'b100, 1);
    drive(3'b111, {2'd0, 2'd0, 2'd1}, {8'h00, 8'h00, 8'h44}, 3'b001, 1);
    drive(3'b000, 6'd0, 24'd0, 3'b000, 0);
    repeat (3) @(posedge clk);

    // Reset in the cycle after an accept: the pending pulse never reaches the bank.
    drive(3'b001, {2'd0, 2'd0, 2'd2}, {8'h00, 8'h00, 8'h99}, 3'b001, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req_valid = 3'b000;
    #1;
    check("midrst_wr_en", 32'(wr_en), 32'd0);
    check("midrst_wr_data", 32'(wr_data), 32'd0);
    last_data = '0;
    #10;
    reset = 1'b1;

    // Pointer is back at R0 after reset.
    drive(3'b110, {2'd1, 2'd2, 2'd0}, {8'h62, 8'h51, 8'h00}, 3'b010, 1);

`ifdef REG_ARB_LOCK_EN
    drive(3'b000, 6'd0, 24'd0, 3'b000, 0);
    drive(3'b100, {2'd0, 2'd0, 2'd0}, {8'h0F, 8'h00, 8'h00}, 3'b100, 1);
    // R0 locks for three accepts, releases on the fourth; R1 follows.
    lock_cfg = 3'b001;
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA0}, 3'b001, 1);
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA1}, 3'b001, 1);
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA2}, 3'b001, 1);
    lock_cfg = 3'b000;
    drive(3'b111, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'hA3}, 3'b001, 1);
    drive(3'b110, {2'd2, 2'd1, 2'd0}, {8'hC2, 8'hB1, 8'h00}, 3'b010, 1);
`endif

    drive(3'b000, 6'd0, 24'd0, 3'b000, 0);
    repeat (4) @(posedge clk);
    #4;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
